// File: rtl/led_seq_ctrl.sv
// LED sequencer: Avalon-MM CSR slave that steps an LED pattern and pushes it
// to a PIO slave through single-cycle Avalon-MM master writes.
// Ports: clk/reset_n; csr_* (zero-wait slave, combinational read);
//        pio_* (write-only master, no waitrequest); busy (enabled or write pending).
module led_seq_ctrl #(
  parameter int LED_W    = 14,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_chipselect,
  input  logic        csr_write_n,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, COUNT, WRITE} state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_t              state, state_nxt;
  logic                en;
  logic [1:0]          mode;
  logic [LED_W-1:0]    pattern, cur, cur_nxt, step_cur;
  logic [PERIOD_W-1:0] period, cnt, cnt_nxt, term_val;
  logic                dir, dir_nxt, step_dir;
  logic                wr, start, stop, reload, terminal;
  logic                unused_wdata;

  assign unused_wdata = ^csr_writedata;

  assign wr     = csr_chipselect & ~csr_write_n;
  // Only enable edges and live pattern reloads redirect the sequencer; other
  // writes (mode/period tweaks) just update registers.
  assign start  = wr && (csr_address == 2'd0) &&  csr_writedata[0] && !en;
  assign stop   = wr && (csr_address == 2'd0) && !csr_writedata[0] &&  en;
  assign reload = wr && (csr_address == 2'd1) && en;

  // A period of zero is stepped like a period of one.
  assign term_val = (period == '0) ? '0 : period - 1'b1;
  assign terminal = (state == COUNT) && (cnt == term_val);

  assign busy = en | (state == WRITE);

  // CSR registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      mode    <= 2'd0;
      pattern <= '0;
      period  <= '0;
    end else if (wr) begin
      case (csr_address)
        2'd0: begin
          en   <= csr_writedata[0];
          mode <= csr_writedata[2:1];
        end
        2'd1:    pattern <= csr_writedata[LED_W-1:0];
        2'd2:    period  <= csr_writedata[PERIOD_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_readdata = '0;
    case (csr_address)
      2'd0: begin
        csr_readdata[0]   = en;
        csr_readdata[2:1] = mode;
      end
      2'd1: csr_readdata[LED_W-1:0]    = pattern;
      2'd2: csr_readdata[PERIOD_W-1:0] = period;
      default: begin
        csr_readdata[0]            = busy;
        csr_readdata[1]            = dir;
        csr_readdata[LED_W+15:16]  = cur;
      end
    endcase
  end

  // Next pattern for one step in the current mode.
  always_comb begin
    step_cur = cur;
    step_dir = dir;
    case (mode)
      2'd0: step_cur = pattern;
      2'd1: step_cur = {cur[LED_W-2:0], cur[LED_W-1]};
      2'd2: begin
        if (dir == DIR_LEFT) begin
          step_cur = cur << 1;
          if (step_cur[LED_W-1]) step_dir = DIR_RIGHT;
        end else begin
          step_cur = cur >> 1;
          if (step_cur[0]) step_dir = DIR_LEFT;
        end
      end
      default: step_cur = (cur == '0) ? pattern : '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cur   <= '0;
      dir   <= DIR_LEFT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      dir   <= dir_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    dir_nxt        = dir;
    cnt_nxt        = cnt;
    pio_address    = 2'd0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    case (state)
      IDLE: ;
      COUNT: begin
        if (terminal) begin
          cnt_nxt   = '0;
          cur_nxt   = step_cur;
          dir_nxt   = step_dir;
          state_nxt = WRITE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        pio_chipselect            = 1'b1;
        pio_write_n               = 1'b0;
        pio_writedata[LED_W-1:0]  = cur;
        state_nxt                 = en ? COUNT : IDLE;
      end
    endcase
    // Redirecting CSR writes override any pending tick step; during WRITE the
    // current write still completes and the forced write follows next cycle.
    if (start) begin
      cur_nxt   = pattern;
      dir_nxt   = DIR_LEFT;
      cnt_nxt   = '0;
      state_nxt = WRITE;
    end else if (stop) begin
      cur_nxt   = '0;
      cnt_nxt   = '0;
      state_nxt = WRITE;
    end else if (reload) begin
      cur_nxt   = csr_writedata[LED_W-1:0];
      cnt_nxt   = '0;
      state_nxt = WRITE;
    end
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 14, meaning width of the LED PIO data register.
REQ-002 SHALL have parameter PERIOD_W, default 24, meaning width of the step-period counter and PERIOD register.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports csr_address input 2, csr_chipselect input 1, csr_write_n input 1, csr_writedata input 32, csr_readdata output 32: Avalon-MM CSR slave, zero wait states, combinational read.
REQ-006 SHALL have ports pio_address output 2, pio_chipselect output 1, pio_write_n output 1, pio_writedata output 32: Avalon-MM master driving the LED PIO slave, single-cycle writes, no waitrequest.
REQ-007 SHALL have port busy, output, 1: high while the sequencer is enabled or a PIO write is pending.

Function
REQ-008 CSR map SHALL be: 0 CTRL (bit0 EN, bits2:1 MODE), 1 PATTERN[LED_W-1:0], 2 PERIOD[PERIOD_W-1:0], 3 STATUS (read-only: bit0 busy, bit1 DIR, bits LED_W+15:16 CUR); unused bits read 0, writes to 3 ignored.
REQ-009 CSR write SHALL occur when csr_chipselect=1 and csr_write_n=0; takes effect on the next clk edge.
REQ-010 MODE SHALL select: 0 static (CUR=PATTERN), 1 chase (rotate CUR left by 1 within LED_W bits), 2 bounce (shift in DIR direction, reverse DIR when bit LED_W-1 (left) or bit 0 (right) is set after the shift), 3 blink (CUR toggles between PATTERN and 0).
REQ-011 FSM SHALL have states IDLE, COUNT, WRITE; reset state IDLE.
REQ-012 IDLE -> WRITE when EN is written 1 (loads CUR=PATTERN, DIR=left, tick counter=0).
REQ-013 COUNT: tick counter increments each cycle; when counter = max(PERIOD,1)-1, counter clears, CUR updates per MODE, FSM -> WRITE.
REQ-014 WRITE SHALL last exactly one cycle: pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={zeros,CUR}; then -> COUNT if EN=1, else IDLE.
REQ-015 Outside WRITE: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-016 PERIOD=0 SHALL behave as PERIOD=1 (one step per two cycles: one COUNT, one WRITE).
REQ-017 PATTERN write while EN=1 SHALL load CUR=PATTERN, clear tick counter and force WRITE next cycle.
REQ-018 EN written 0 while EN=1 SHALL force one WRITE of all-zero data (LEDs cleared), then IDLE; counter cleared.
REQ-019 CSR write coinciding with a terminal tick SHALL take priority; the tick step is discarded.
REQ-020 CSR write during WRITE cycle SHALL not shorten that write; its effect (REQ-017/018) follows in the next cycle.
REQ-021 MODE change while running SHALL take effect at the next step without reloading CUR; bounce with CUR=0 SHALL stay 0.
REQ-022 busy SHALL equal (EN=1) or (state=WRITE).

Reset
REQ-023 On reset_n=0, asynchronously: state IDLE, CTRL=0, PATTERN=0, PERIOD=0, CUR=0, DIR=left, counter=0, busy=0, all pio_* outputs at REQ-015 values.
REQ-024 Reset mid-WRITE SHALL terminate the write immediately; no PIO write issued after release until EN is rewritten.

Verification
REQ-025 Reset release -> csr_readdata=0 at all addresses, pio_chipselect=0, busy=0.
REQ-026 PATTERN=0x0001, PERIOD=3, CTRL=0b011 (chase) -> PIO writes 0x0001, then 0x0002, 0x0004 every 4 cycles; 14th step wraps 0x2000->0x0001.
REQ-027 PATTERN=0x0001, MODE=2 bounce, PERIOD=1 -> writes walk to 0x2000, DIR bit flips, next write 0x1000.
REQ-028 MODE=3, PATTERN=0x3FFF, PERIOD=0 -> alternating writes 0x3FFF/0x0000 every 2 cycles.
REQ-029 While running, write CTRL=0 on a terminal-tick cycle -> single write 0x0000, busy low after it, no further PIO writes.
REQ-030 Assert reset_n=0 during a WRITE cycle -> pio_chipselect drops same cycle; after release no write until CTRL.EN=1.
